// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time, answered after LATENCY cycles.
// Define DM_WRITE_LOG_EN to print one line per committed store (simulation only).
module dm_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  width_q;
    logic        sign_q;
    logic [31:0] pc_q;

    // Storage words carry no reset; the per-word valid bit makes a cleared word read as 0.
    logic [31:0]      mem_q [DEPTH];
    logic [DEPTH-1:0] wvld_q;

    logic                  accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           cur_word;
    logic [31:0]           merged;
    logic [31:0]           load_val;
    logic                  acc_err;

    function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [1:0]  width,
                                                input logic [1:0]  ln);
        logic [31:0] r;
        r = old_w;
        case (width)
            W_WORD:  r = wd;
            W_HALF:  if (ln[1]) r[31:16] = wd[15:0];
                     else       r[15:0]  = wd[15:0];
            W_BYTE:  r[{ln, 3'b000} +: 8] = wd[7:0];
            default: r = old_w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [1:0]  width,
                                                input logic [1:0]  ln,
                                                input logic        sgn);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = ln[1] ? w[31:16] : w[15:0];
        b = w[{ln, 3'b000} +: 8];
        case (width)
            W_WORD:  r = w;
            W_HALF:  r = {{16{sgn & h[15]}}, h};
            W_BYTE:  r = {{24{sgn & b[7]}}, b};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign word_idx = addr_q[ADDR_WIDTH+1:2];
    assign lane     = addr_q[1:0];
    assign cur_word = wvld_q[word_idx] ? mem_q[word_idx] : 32'd0;
    assign merged   = merge_store(cur_word, wdata_q, width_q, lane);
    assign load_val = extend_load(cur_word, width_q, lane, sign_q);

    always_comb begin
        acc_err = 1'b0;
        case (width_q)
            W_WORD:  acc_err = (lane != 2'b00);
            W_HALF:  acc_err = lane[0];
            W_BYTE:  acc_err = 1'b0;
            default: acc_err = 1'b1;
        endcase
        if ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0) acc_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = LAT_M1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (acc_err) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else begin
                        rdata_d = we_q ? 32'd0 : load_val;
                        err_d   = 1'b0;
                        mem_we  = we_q;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            wvld_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (mem_we) begin
                mem_q[word_idx]  <= merged;
                wvld_q[word_idx] <= 1'b1;
`ifdef DM_WRITE_LOG_EN
                $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, merged);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            width_q <= req_width;
            sign_q  <= req_sign;
            pc_q    <= req_pc;
        end
    end

`ifndef DM_WRITE_LOG_EN
    // The latched pc only feeds the write log.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed steps plus random traffic against a byte-addressed reference model.
module tb_dm_responder;

    localparam int AW  = 12;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance (LATENCY=2)
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic [1:0]  req_width = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .req_sign(req_sign), .req_pc(req_pc), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Throughput instances (LATENCY=1 and 15), fed a constant word load
    logic        rst_x = 1'b1, v_x = 1'b0;
    logic        c_we = 1'b0, c_sign = 1'b0;
    logic [31:0] c_addr = 32'h0000_0040, c_wdata = '0, c_pc = '0;
    logic [1:0]  c_width = 2'b00;
    logic        rdy1, rv1, err1, rdy15, rv15, err15;
    logic [31:0] rd1, rd15;

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(rst_x), .req_valid(v_x), .req_ready(rdy1),
        .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_width(c_width),
        .req_sign(c_sign), .req_pc(c_pc), .resp_valid(rv1),
        .resp_rdata(rd1), .resp_err(err1)
    );

    dm_responder #(.ADDR_WIDTH(AW), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(rst_x), .req_valid(v_x), .req_ready(rdy15),
        .req_we(c_we), .req_addr(c_addr), .req_wdata(c_wdata), .req_width(c_width),
        .req_sign(c_sign), .req_pc(c_pc), .resp_valid(rv15),
        .resp_rdata(rd15), .resp_err(err15)
    );

    int acc1[$];
    int acc15[$];
    int dbl1 = 0, dbl15 = 0;
    logic prev1 = 1'b0, prev15 = 1'b0;

    always @(negedge clk) begin
        if (!rst_x) begin
            if (v_x && rdy1)  acc1.push_back(cyc);
            if (v_x && rdy15) acc15.push_back(cyc);
            if (rv1 && prev1)   dbl1++;
            if (rv15 && prev15) dbl15++;
            prev1  <= rv1;
            prev15 <= rv15;
        end
    end

    // Reference model: little-endian byte memory; absent bytes read as 0
    logic [7:0] ref_mem [int];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] width, input logic sign,
                                  output logic [31:0] rdata, output logic err);
        int nb;
        longint unsigned a;
        logic [31:0] v;
        a  = addr;
        nb = (width == 2'b00) ? 4 : (width == 2'b01) ? 2 : (width == 2'b10) ? 1 : 0;
        err = 1'b0;
        if (nb == 0) err = 1'b1;
        else if ((a % nb) != 0) err = 1'b1;
        if (a >= (longint'(4) << AW)) err = 1'b1;
        rdata = 32'd0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++)
                if (ref_mem.exists(int'(a) + i)) v[8*i +: 8] = ref_mem[int'(a) + i];
            if (sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rdata = v;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the main instance and check latency, data, error and pulse width
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] width, input logic sign, input string tag,
                       output logic [31:0] got);
        logic [31:0] er;
        logic        ee;
        int          n;
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_width = width; req_sign = sign; req_pc = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model(we, addr, wdata, width, sign, er, ee);
        n = 0;
        while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_rdata"}, resp_rdata, er);
        check({tag, "_err"}, 32'(resp_err), 32'(ee));
        got = resp_rdata;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  w;
        int          r;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        ref_mem.delete();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);

        // Word store / load
        txn(1'b1, 32'h10, 32'h1234_5678, 2'b00, 1'b0, "t1_st", got);
        txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, "t1_ld", got);
        check("t1_word", got, 32'h1234_5678);

        // Byte store and sign/zero extended byte loads
        txn(1'b1, 32'h11, 32'h0000_00AB, 2'b10, 1'b0, "t2_st", got);
        txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, "t2_wd", got);
        check("t2_word", got, 32'h1234_AB78);
        txn(1'b0, 32'h11, 32'h0, 2'b10, 1'b1, "t2_lbs", got);
        check("t2_sbyte", got, 32'hFFFF_FFAB);
        txn(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, "t2_lbu", got);
        check("t2_ubyte", got, 32'h0000_00AB);

        // Half store and half loads
        txn(1'b1, 32'h12, 32'h0000_8001, 2'b01, 1'b0, "t3_st", got);
        txn(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, "t3_lhs", got);
        check("t3_shalf", got, 32'hFFFF_8001);
        txn(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, "t3_lhu", got);
        check("t3_uhalf", got, 32'h0000_8001);
        txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, "t3_wd", got);
        check("t3_word", got, 32'h8001_AB78);

        // Error cases; memory must be untouched
        txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, "t4_mis_w", got);
        txn(1'b1, 32'h15, 32'hDEAD_BEEF, 2'b01, 1'b0, "t4_mis_h", got);
        txn(1'b1, 32'h14, 32'hDEAD_BEEF, 2'b11, 1'b0, "t4_width", got);
        txn(1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 2'b00, 1'b0, "t4_range", got);
        txn(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2'b00, 1'b0, "t4_edge", got);
        txn(1'b0, 32'h14, 32'h0, 2'b00, 1'b0, "t4_w14", got);
        check("t4_w14_val", got, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, "t4_w10", got);
        check("t4_w10_val", got, 32'h8001_AB78);
        txn(1'b1, 32'h3FFC, 32'hCAFE_F00D, 2'b00, 1'b0, "t4_top_st", got);
        txn(1'b0, 32'h3FFC, 32'h0, 2'b00, 1'b0, "t4_top_ld", got);
        check("t4_top_val", got, 32'hCAFE_F00D);

        // Reset while BUSY: request dropped, memory cleared
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5_5A5A;
        req_width = 2'b00; req_sign = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_mem.delete();
        check("t5_valid", 32'(resp_valid), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd1);
        check("t5_rdata", resp_rdata, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("t5_noresp", 32'(resp_valid), 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b0, "t5_ld20", got);
        check("t5_w20", got, 32'h0);
        txn(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, "t5_ld10", got);
        check("t5_w10", got, 32'h0);

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = 32'h0000_4000 + $urandom_range(0, 15);
            else if (r == 1) a = 32'h0000_3FF0 + $urandom_range(0, 15);
            else if (r == 2) a = $urandom;
            else             a = $urandom_range(0, 63);
            r = $urandom_range(0, 9);
            w = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            txn(1'($urandom_range(0, 1)), a, $urandom, w, 1'($urandom_range(0, 1)), "rnd", got);
        end

        // Continuous req_valid on LATENCY=1 and LATENCY=15 instances
        @(posedge clk); #1;
        rst_x = 1'b0;
        v_x   = 1'b1;
        repeat (80) @(posedge clk);
        #1 v_x = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("l1_count", 32'(acc1.size() >= 20), 32'd1);
        check("l15_count", 32'(acc15.size() >= 4), 32'd1);
        for (int i = 1; i < acc1.size(); i++)
            check("l1_gap", 32'(acc1[i] - acc1[i-1]), 32'd3);
        for (int i = 1; i < acc15.size(); i++)
            check("l15_gap", 32'(acc15[i] - acc15[i-1]), 32'd17);
        check("l1_dbl", 32'(dbl1), 32'd0);
        check("l15_dbl", 32'(dbl15), 32'd0);
        check("l1_rdata", rd1, 32'd0);
        check("l15_err", 32'(err15), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
